// File: rtl/wdi_mon.sv
// Watchdog-input monitor for the STM32 kick line: checks that wdi toggles neither too
// fast nor too slow, pulses mcu_rst_n on a fault and counts faults.
module wdi_mon #(
  parameter logic [23:0] TP_TO  = 24'd1_000_000,
  parameter logic [23:0] TP_MIN = 24'd1_000,
  parameter logic [23:0] TP_RST = 24'd50_000
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       wdi,
  input  logic       wd_en,
  input  logic       wd_clr,
  output logic       wd_alarm,
  output logic       mcu_rst_n,
  output logic       led_n,
  output logic [7:0] err_cnt,
  output logic [1:0] wd_state
);

  typedef enum logic [1:0] {
    S_DIS   = 2'd0,
    S_WAIT  = 2'd1,
    S_RUN   = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t      state;
  logic        s1, s2, hist;
  logic        wdi_edge;
  logic        to_fault;
  logic [23:0] cnt;
  logic [23:0] rcnt;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      hist <= 1'b0;
    end else begin
      s1   <= wdi;
      s2   <= s1;
      hist <= s2;
    end
  end

  assign wdi_edge = s2 ^ hist;

  // An edge in the timeout cycle counts as a kick, so the edge test takes priority.
  assign to_fault = (state == S_RUN) &&
                    (wdi_edge ? (cnt < TP_MIN) : (cnt >= TP_TO - 24'd1));

  // led_n tracks s1 here so that it equals ~s2 alongside the registered state.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_DIS;
      cnt       <= '0;
      rcnt      <= '0;
      wd_alarm  <= 1'b0;
      mcu_rst_n <= 1'b1;
      led_n     <= 1'b1;
      err_cnt   <= '0;
    end else if (!wd_en) begin
      state     <= S_DIS;
      cnt       <= '0;
      rcnt      <= '0;
      wd_alarm  <= 1'b0;
      mcu_rst_n <= 1'b1;
      led_n     <= 1'b1;
    end else if (to_fault) begin
      state     <= S_FAULT;
      cnt       <= '0;
      rcnt      <= TP_RST - 24'd1;
      wd_alarm  <= 1'b1;
      mcu_rst_n <= 1'b0;
      led_n     <= 1'b0;
      if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end else begin
      case (state)
        S_DIS: begin
          state <= S_WAIT;
          led_n <= ~s1;
        end
        S_WAIT: begin
          led_n <= ~s1;
          cnt   <= '0;
          if (wdi_edge) state <= S_RUN;
        end
        S_RUN: begin
          led_n <= ~s1;
          if (wdi_edge)              cnt <= '0;
          else if (cnt != 24'hFF_FFFF) cnt <= cnt + 24'd1;
        end
        S_FAULT: begin
          if (!mcu_rst_n) begin
            if (rcnt == 24'd0) mcu_rst_n <= 1'b1;
            else               rcnt      <= rcnt - 24'd1;
          end else if (wd_clr) begin
            state    <= S_WAIT;
            wd_alarm <= 1'b0;
            led_n    <= ~s1;
          end
        end
        default: state <= S_DIS;
      endcase
    end
  end

  assign wd_state = state;

endmodule

// File: tb/tb_wdi_mon.sv
// Randomized bench for wdi_mon against a timestamp-based model of the watchdog rules.
module tb_wdi_mon;
  localparam int TO  = 100;
  localparam int MIN = 10;
  localparam int RST = 20;

  logic       clk_sys = 1'b0;
  logic       rst_n   = 1'b1;
  logic       wdi     = 1'b0;
  logic       wd_en   = 1'b0;
  logic       wd_clr  = 1'b0;
  logic       wd_alarm, mcu_rst_n, led_n;
  logic [7:0] err_cnt;
  logic [1:0] wd_state;

  wdi_mon #(.TP_TO(24'd100), .TP_MIN(24'd10), .TP_RST(24'd20)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .wdi(wdi), .wd_en(wd_en), .wd_clr(wd_clr),
    .wd_alarm(wd_alarm), .mcu_rst_n(mcu_rst_n), .led_n(led_n),
    .err_cnt(err_cnt), .wd_state(wd_state)
  );

  always #5 clk_sys = ~clk_sys;

  int n_chk = 0;
  int n_err = 0;
  int tog_cnt = 0;

  // Model: state plus absolute cycle stamps of the last kick and the fault entry.
  int cyc = 0;
  int m_state, last_acc, fault_at, m_err;
  bit wq[3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic model_rst();
    m_state = 0; m_err = 0; last_acc = 0; fault_at = 0;
    wq[0] = 0; wq[1] = 0; wq[2] = 0;
  endtask

  task automatic model_tick();
    bit e, flt;
    int gap;
    cyc++;
    if (!rst_n) begin model_rst(); return; end
    e = wq[1] ^ wq[2];
    wq[2] = wq[1]; wq[1] = wq[0]; wq[0] = wdi;
    flt = 0;
    if (!wd_en) m_state = 0;
    else case (m_state)
      0: m_state = 1;
      1: if (e) begin m_state = 2; last_acc = cyc; end
      2: begin
        gap = cyc - last_acc;
        if (e) begin
          if (gap - 1 < MIN) flt = 1; else last_acc = cyc;
        end else if (gap >= TO) flt = 1;
      end
      default: if (wd_clr && (cyc - 1 >= fault_at + RST)) m_state = 1;
    endcase
    if (flt) begin
      m_state = 3; fault_at = cyc;
      if (m_err < 255) m_err++;
    end
  endtask

  task automatic check_model();
    chk("state", wd_state, m_state);
    chk("alarm", wd_alarm, m_state == 3);
    chk("mcu_rst_n", mcu_rst_n, !(m_state == 3 && cyc < fault_at + RST));
    chk("led_n", led_n, (m_state == 0) ? 1 : (m_state == 3) ? 0 : !wq[1]);
    chk("err_cnt", err_cnt, m_err);
  endtask

  task automatic step();
    @(posedge clk_sys);
    model_tick();
    @(negedge clk_sys);
    check_model();
  endtask

  // per=0: wdi held; clr_mode 0 none, 1 every cycle, 2 random
  task automatic run(input int n, input int per, input int clr_mode);
    for (int i = 0; i < n; i++) begin
      step();
      wd_clr = 1'b0;
      if (per > 0) begin
        tog_cnt++;
        if (tog_cnt >= per) begin wdi = ~wdi; tog_cnt = 0; end
      end
      if (clr_mode == 1) wd_clr = 1'b1;
      else if (clr_mode == 2) wd_clr = ($urandom_range(15) == 0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_rst();
    #1;
    chk("rst_state", wd_state, 0);
    chk("rst_alarm", wd_alarm, 0);
    chk("rst_mcu", mcu_rst_n, 1);
    chk("rst_led", led_n, 1);
    chk("rst_err", err_cnt, 0);
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int w, n;
    bit hit;
    model_rst();
    #2;
    do_reset();

    // stays disabled until wd_en is seen
    run(5, 0, 0);
    wd_en = 1'b1;

    // steady kicking every 50 cycles
    tog_cnt = 0;
    run(1000, 50, 0);
    chk("r31_state", wd_state, 2);
    chk("r31_alarm", wd_alarm, 0);
    chk("r31_mcu", mcu_rst_n, 1);
    chk("r31_err", err_cnt, 0);

    // stop kicking -> timeout fault, reset pulse, clear handling
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      step();
      hit = (wd_state == 2'd3);
    end
    chk("to_fault_seen", hit, 1);
    w = (mcu_rst_n == 1'b0) ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      wd_clr = (i == 8) || (i == 30);
      step();
      if (!mcu_rst_n) w++;
      if (i == 8) chk("clr_in_pulse", wd_state, 3);
    end
    wd_clr = 1'b0;
    chk("pulse_w", w, RST);
    chk("to_err", err_cnt, 1);
    chk("clr_state", wd_state, 1);
    chk("clr_alarm", wd_alarm, 0);

    // two kicks 5 cycles apart -> too-fast fault
    wdi = ~wdi; run(30, 0, 0);
    wdi = ~wdi; run(5, 0, 0);
    wdi = ~wdi; run(5, 0, 0);
    chk("fast_state", wd_state, 3);
    chk("fast_err", err_cnt, 2);
    wd_en = 1'b0;
    step();
    chk("dis_state", wd_state, 0);
    chk("dis_mcu", mcu_rst_n, 1);
    wd_en = 1'b1;

    // period boundaries: 100 ok, 101 timeout, 11 ok, 10 too fast
    tog_cnt = 0; run(450, 100, 0);
    chk("p100_state", wd_state, 2);
    chk("p100_err", err_cnt, 2);
    tog_cnt = 0; run(300, 101, 0);
    chk("p101_state", wd_state, 3);
    chk("p101_err", err_cnt, 3);
    wd_en = 1'b0; step(); wd_en = 1'b1;
    tog_cnt = 0; run(300, 11, 0);
    chk("p11_state", wd_state, 2);
    chk("p11_err", err_cnt, 3);
    tog_cnt = 0; run(100, 10, 0);
    chk("p10_state", wd_state, 3);
    chk("p10_err", err_cnt, 4);

    // random kicks, clears and enable drops
    n = 3;
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) n = $urandom_range(120, 3);
      run(1, n, 2);
      wd_en = ($urandom_range(199) != 0);
    end
    wd_en = 1'b1;

    // hammer faults until err_cnt saturates
    tog_cnt = 0;
    run(8000, 3, 1);
    chk("sat_err", err_cnt, 255);
    hit = 0;
    for (int i = 0; i < 60 && !hit; i++) begin
      run(1, 3, 1);
      hit = !mcu_rst_n;
    end
    chk("sat_pulse_seen", hit, 1);
    wd_clr = 1'b0;
    do_reset();
    chk("post_rst_state", wd_state, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
